// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus; master side is the fetch unit.
interface fetch_unit_if #(
  parameter int PC_WIDTH          = 32,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                         imem_req_o;
  logic [PC_WIDTH-1:0]          imem_addr_o;
  logic                         imem_gnt_i;
  logic                         imem_rvalid_i;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one imem request in flight and feeds
// the F/D register, substituting a NOP bubble when nothing valid is available.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                PC_WIDTH          = 32,
  parameter int                INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         StallF_i,
  input  logic                         PCSrcE_i,
  input  logic [PC_WIDTH-1:0]          PCTargetE_i,
  fetch_unit_if.master                 imem,
  output logic [PC_WIDTH-1:0]          PCF_o,
  output logic [PC_WIDTH-1:0]          PCPlus4F_o,
  output logic [INSTRUCTION_WIDTH-1:0] InstrF_o,
  output logic                         ValidF_o
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_INSTR);

  fetch_state_e                 r_state, w_state_d;
  logic [PC_WIDTH-1:0]          r_pc, w_pc_d, w_pc_plus4;
  logic [INSTRUCTION_WIDTH-1:0] r_instr_buf, w_instr_buf_d;

  assign w_pc_plus4 = r_pc + PC_WIDTH'(PC_INC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr_buf <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_instr_buf <= w_instr_buf_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_pc_d           = r_pc;
    w_instr_buf_d    = r_instr_buf;
    imem.imem_req_o  = 1'b0;
    imem.imem_addr_o = r_pc;
    ValidF_o         = 1'b0;
    InstrF_o         = NOP;

    unique case (r_state)
      S_IDLE: begin
        w_state_d = S_REQ;
        if (PCSrcE_i) w_pc_d = PCTargetE_i;
      end

      S_REQ: begin
        // Redirect withdraws an ungranted request and retries at the target.
        if (PCSrcE_i) begin
          w_pc_d = PCTargetE_i;
        end else begin
          imem.imem_req_o = 1'b1;
          if (imem.imem_gnt_i) w_state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem.imem_rvalid_i) begin
          ValidF_o = 1'b1;
          InstrF_o = imem.imem_rdata_i;
        end
        if (PCSrcE_i) begin
          w_pc_d    = PCTargetE_i;
          w_state_d = imem.imem_rvalid_i ? S_REQ : S_DRAIN;
        end else if (imem.imem_rvalid_i) begin
          if (StallF_i) begin
            w_instr_buf_d = imem.imem_rdata_i;
            w_state_d     = S_HOLD;
          end else begin
            // Back-to-back issue keeps zero-wait memory at one instr/cycle.
            w_pc_d           = w_pc_plus4;
            imem.imem_req_o  = 1'b1;
            imem.imem_addr_o = w_pc_plus4;
            w_state_d        = imem.imem_gnt_i ? S_WAIT : S_REQ;
          end
        end
      end

      S_HOLD: begin
        ValidF_o = 1'b1;
        InstrF_o = r_instr_buf;
        if (PCSrcE_i) begin
          w_pc_d    = PCTargetE_i;
          w_state_d = S_REQ;
        end else if (!StallF_i) begin
          w_pc_d    = w_pc_plus4;
          w_state_d = S_REQ;
        end
      end

      S_DRAIN: begin
        // Stale response still owed by memory; swallow it before re-issuing.
        if (PCSrcE_i) w_pc_d = PCTargetE_i;
        if (imem.imem_rvalid_i) w_state_d = S_REQ;
      end

      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  assign PCF_o      = r_pc;
  assign PCPlus4F_o = w_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a single-outstanding imem responder
// that returns the request address as the instruction word.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, pcsrc;
  logic [31:0] tgt;
  logic [31:0] pcf, pcp4, instr;
  logic        valid;

  logic        gnt_en;
  int unsigned lat;
  logic        r_pend;
  int unsigned r_cnt;
  logic [31:0] r_paddr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32)) imem ();

  fetch_unit #(
    .PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(32'h0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .StallF_i    (stall),
    .PCSrcE_i    (pcsrc),
    .PCTargetE_i (tgt),
    .imem        (imem.master),
    .PCF_o       (pcf),
    .PCPlus4F_o  (pcp4),
    .InstrF_o    (instr),
    .ValidF_o    (valid)
  );

  assign imem.imem_gnt_i    = imem.imem_req_o & gnt_en;
  assign imem.imem_rvalid_i = r_pend && (r_cnt == 0);
  assign imem.imem_rdata_i  = r_paddr;

  // lat = cycles from grant to rvalid (1 = next cycle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_cnt   <= 0;
      r_paddr <= '0;
    end else begin
      if (imem.imem_rvalid_i) r_pend <= 1'b0;
      if (imem.imem_req_o && imem.imem_gnt_i) begin
        r_pend  <= 1'b1;
        r_paddr <= imem.imem_addr_o;
        r_cnt   <= lat - 1;
      end else if (r_pend && r_cnt != 0) begin
        r_cnt <= r_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    stall  = 1'b0;
    pcsrc  = 1'b0;
    tgt    = '0;
    gnt_en = 1'b1;
    lat    = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pcsrc = 1'b0; tgt = '0; gnt_en = 1'b1; lat = 1;

    // reset values, then zero-wait streaming 0,4,8 with a 3-cycle stall on 4
    repeat (2) @(negedge clk);
    chk("rst_pcf",   pcf, 32'h0);
    chk("rst_pcp4",  pcp4, 32'h4);
    chk("rst_req",   {31'b0, imem.imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req0_req",   {31'b0, imem.imem_req_o}, 32'h1);
    chk("req0_addr",  imem.imem_addr_o, 32'h0);
    chk("req0_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    chk("i0_valid", {31'b0, valid}, 32'h1);
    chk("i0_instr", instr, 32'h0);
    chk("i0_addr",  imem.imem_addr_o, 32'h4);
    @(negedge clk);
    chk("i4_valid", {31'b0, valid}, 32'h1);
    chk("i4_instr", instr, 32'h4);
    chk("i4_pcf",   pcf, 32'h4);
    stall = 1'b1; #1;
    chk("stall_req0", {31'b0, imem.imem_req_o}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_pcf",   pcf, 32'h4);
      chk("hold_instr", instr, 32'h4);
      chk("hold_valid", {31'b0, valid}, 32'h1);
      chk("hold_req",   {31'b0, imem.imem_req_o}, 32'h0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("res_req",   {31'b0, imem.imem_req_o}, 32'h1);
    chk("res_addr",  imem.imem_addr_o, 32'h8);
    chk("res_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    chk("i8_instr", instr, 32'h8);
    chk("i8_valid", {31'b0, valid}, 32'h1);

    // redirect to 0x100 while fetch of 0x10 is in flight (slow memory)
    do_reset();
    lat = 4; pcsrc = 1'b1; tgt = 32'h10;
    @(negedge clk);
    pcsrc = 1'b0; #1;
    chk("fl_addr", imem.imem_addr_o, 32'h10);
    chk("fl_req",  {31'b0, imem.imem_req_o}, 32'h1);
    @(negedge clk);
    chk("fl_wait_valid", {31'b0, valid}, 32'h0);
    pcsrc = 1'b1; tgt = 32'h100; #1;
    chk("fl_redir_req", {31'b0, imem.imem_req_o}, 32'h0);
    @(negedge clk);
    pcsrc = 1'b0; #1;
    chk("dr_pcf",   pcf, 32'h100);
    chk("dr_valid", {31'b0, valid}, 32'h0);
    chk("dr_req",   {31'b0, imem.imem_req_o}, 32'h0);
    @(negedge clk);
    chk("dr_valid2", {31'b0, valid}, 32'h0);
    @(negedge clk);
    chk("dr_rvalid", {31'b0, imem.imem_rvalid_i}, 32'h1);
    chk("dr_stale",  {31'b0, valid}, 32'h0);
    chk("dr_req3",   {31'b0, imem.imem_req_o}, 32'h0);
    @(negedge clk);
    chk("dr_newreq",  {31'b0, imem.imem_req_o}, 32'h1);
    chk("dr_newaddr", imem.imem_addr_o, 32'h100);

    // redirect coinciding with rvalid
    do_reset();
    @(negedge clk);
    chk("co_addr0", imem.imem_addr_o, 32'h0);
    @(negedge clk);
    chk("co_rvalid", {31'b0, imem.imem_rvalid_i}, 32'h1);
    pcsrc = 1'b1; tgt = 32'h200; #1;
    chk("co_req", {31'b0, imem.imem_req_o}, 32'h0);
    @(negedge clk);
    pcsrc = 1'b0; #1;
    chk("co_valid", {31'b0, valid}, 32'h0);
    chk("co_pcf",   pcf, 32'h200);
    chk("co_req2",  {31'b0, imem.imem_req_o}, 32'h1);
    chk("co_addr",  imem.imem_addr_o, 32'h200);
    @(negedge clk);
    chk("co_instr", instr, 32'h200);

    // grant withheld 4 cycles, then redirect while still ungranted
    do_reset();
    gnt_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("ng_addr",  imem.imem_addr_o, 32'h0);
      chk("ng_req",   {31'b0, imem.imem_req_o}, 32'h1);
      chk("ng_valid", {31'b0, valid}, 32'h0);
      @(negedge clk);
    end
    pcsrc = 1'b1; tgt = 32'h300; #1;
    chk("ng_redir_req", {31'b0, imem.imem_req_o}, 32'h0);
    @(negedge clk);
    pcsrc = 1'b0; #1;
    chk("ng_taddr", imem.imem_addr_o, 32'h300);
    chk("ng_treq",  {31'b0, imem.imem_req_o}, 32'h1);
    chk("ng_tval",  {31'b0, valid}, 32'h0);
    gnt_en = 1'b1;
    @(negedge clk);
    chk("ng_instr", instr, 32'h300);
    chk("ng_valid2", {31'b0, valid}, 32'h1);

    // PC wrap at top of address space
    do_reset();
    pcsrc = 1'b1; tgt = 32'hFFFF_FFFC;
    @(negedge clk);
    pcsrc = 1'b0; #1;
    chk("wr_addr", imem.imem_addr_o, 32'hFFFF_FFFC);
    chk("wr_pcp4", pcp4, 32'h0);
    @(negedge clk);
    chk("wr_instr", instr, 32'hFFFF_FFFC);
    chk("wr_next",  imem.imem_addr_o, 32'h0);
    @(negedge clk);
    chk("wr_pcf",    pcf, 32'h0);
    chk("wr_instr0", instr, 32'h0);
    chk("wr_valid0", {31'b0, valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter, issues instruction-memory requests over a req/gnt/rvalid handshake and applies redirects from execute and stalls from the hazard unit. It presents PCF_o, InstrF_o and PCPlus4F_o, plus a valid flag, directly to the Fetch/Decode pipeline register. When no instruction is available it presents a NOP bubble instead.

## Interface
- PC_WIDTH, 32, program-counter and memory-address width
- INSTRUCTION_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- StallF_i  in  1  hazard unit: decode cannot accept, hold current fetch result
- PCSrcE_i  in  1  execute: taken branch/jump, redirect fetch
- PCTargetE_i  in  PC_WIDTH  redirect target, used unmodified
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  PC_WIDTH  fetch address
- imem_gnt_i  in  1  memory accepted the request this cycle
- imem_rvalid_i  in  1  response data valid, at most one per granted request, in order
- imem_rdata_i  in  INSTRUCTION_WIDTH  response instruction
- PCF_o  out  PC_WIDTH  PC of the presented instruction (= pc_q)
- PCPlus4F_o  out  PC_WIDTH  pc_q + 4
- InstrF_o  out  INSTRUCTION_WIDTH  instruction, or NOP 32'h0000_0013 when ValidF_o=0
- ValidF_o  out  1  InstrF_o is a real fetched instruction

## Operation
- Registers: pc_q, state, instr_buf. At most one request outstanding.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Consume condition = ValidF_o & ~StallF_i & ~PCSrcE_i.
- PCSrcE_i has priority in every state: pc_q <= PCTargetE_i, imem_req_o=0 that cycle.
- IDLE: imem_req_o=0. Next state REQ; a redirect still updates pc_q.
- REQ: imem_req_o=1, imem_addr_o=pc_q.
  - Redirect: stay REQ. Withdrawing an ungranted request is legal on this bus.
  - gnt: go to WAIT. Otherwise stay REQ.
- WAIT:
  - rvalid=0, no redirect: stay.
  - rvalid=0, redirect: go to DRAIN.
  - rvalid=1, redirect: discard the response, go to REQ.
  - rvalid=1, StallF_i: instr_buf <= rdata, go to HOLD.
  - rvalid=1, consume: pc_q <= pc_q+4, and issue the next request in the same cycle (imem_req_o=1, imem_addr_o=pc_q+4). gnt → stay WAIT, else → REQ.
- HOLD:
  - Redirect → REQ.
  - StallF_i → stay.
  - Consume → pc_q <= pc_q+4, go to REQ.
- DRAIN: ValidF_o=0. Repeated redirects update pc_q. rvalid → discard, go to REQ.
- Output mux:
  - WAIT & rvalid: ValidF_o=1, InstrF_o=imem_rdata_i (pass-through).
  - HOLD: ValidF_o=1, InstrF_o=instr_buf.
  - Otherwise: ValidF_o=0, InstrF_o=NOP.
- pc_q+4 wraps modulo 2^PC_WIDTH. No misalignment checking.

## Timing
- Reset values (async assert; state is valid from the first edge after deassert):
  - state=IDLE, pc_q=RESET_PC
  - PCF_o=RESET_PC, PCPlus4F_o=RESET_PC+4
  - imem_req_o=0, ValidF_o=0, InstrF_o=NOP, instr_buf=0
- First request: imem_req_o rises one cycle after rst_ni deasserts.
- Latency: zero-wait memory (gnt same cycle, rvalid next cycle):
  - First instruction valid 2 cycles after IDLE exit.
  - Steady state: 1 instruction/cycle.
- Redirect penalty:
  - Nothing in flight: the target request issues the cycle after PCSrcE_i.
  - In flight: the target request issues the cycle after the stale rvalid.
- Reset asserted mid-WAIT: outstanding response is ignored; memory is reset in the same domain.
- StallF_i with ValidF_o=0 has no effect. Requests proceed; stall only blocks consumption.

## Structure
- fetch_pkg:
  - state enum fetch_state_e
  - NOP_INSTR = 32'h0000_0013
  - PC increment constant
- Single module. No sub-module; the FSM and PC datapath are in one file.

## Test plan
- Reset release, zero-wait memory returning addr as data → requests at 0,4,8; InstrF_o=0,4,8 on consecutive cycles, ValidF_o=1 from cycle 2.
- StallF_i high 3 cycles while instr 0x4 is valid → PCF_o=4, InstrF_o=4 held, imem_req_o=0; resumes at 8 after stall drops.
- PCSrcE_i=1, PCTargetE_i=0x100 while a request to 0x10 is in flight (rvalid delayed 3 cycles) → state DRAIN, stale data discarded, ValidF_o=0, next request addr 0x100.
- PCSrcE_i and rvalid in the same cycle → response dropped, ValidF_o=0, pc_q=target, REQ next.
- gnt withheld 4 cycles → imem_addr_o stable, ValidF_o=0 throughout; redirect during the wait changes the address to the target.
- pc_q=0xFFFF_FFFC consumed → PCPlus4F_o=0, next fetch addr 0.
